// File: rtl/gf180mcu_fd_sc_mcu9t5v0_rr_arb2.sv
// Two-requester round-robin arbiter: registered grants, grant hold while the
// request stays high, and optional hold-limit revocation with per-requester block.
//
//   state  | meaning
//   S_IDLE | resource free, no grant outstanding
//   S_OWN1 | requester 1 owns the resource (G1=1)
//   S_OWN2 | requester 2 owns the resource (G2=1)
module gf180mcu_fd_sc_mcu9t5v0_rr_arb2 #(
   parameter int HCW      = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic CLK,
   input  logic RST,
   input  logic A1,
   input  logic A2,
   output logic G1,
   output logic G2,
   output logic Z,
   output logic TO
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OWN1 = 2'd1,
      S_OWN2 = 2'd2
   } state_t;

   localparam bit             HOLD_EN   = (MAX_HOLD > 0);
   localparam logic [HCW-1:0] HOLD_LAST = HOLD_EN ? HCW'(MAX_HOLD - 1) : '0;

   state_t         state_q, state_d;
   logic           pri2_q, pri2_d;
   logic [HCW-1:0] cnt_q, cnt_d;
   logic           blk1_q, blk1_d;
   logic           blk2_q, blk2_d;
   logic           g1_q, g1_d;
   logic           g2_q, g2_d;
   logic           z_q, z_d;
   logic           to_q, to_d;
   logic           e1, e2, hold_hit;

   always_comb begin
      e1       = A1 & ~blk1_q;
      e2       = A2 & ~blk2_q;
      // cnt_q counts completed grant cycles minus one, so this fires on the
      // MAX_HOLD-th cycle of ownership
      hold_hit = HOLD_EN && (cnt_q == HOLD_LAST);
      state_d  = state_q;
      pri2_d   = pri2_q;
      cnt_d    = cnt_q;
      blk1_d   = blk1_q & A1;
      blk2_d   = blk2_q & A2;
      to_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (e1 && (!e2 || !pri2_q)) begin
               state_d = S_OWN1;
               cnt_d   = '0;
            end else if (e2) begin
               state_d = S_OWN2;
               cnt_d   = '0;
            end
         end
         S_OWN1: begin
            if (!A1 || hold_hit) begin
               pri2_d = 1'b1;
               if (A1) begin
                  to_d   = 1'b1;
                  blk1_d = 1'b1;
               end
               if (e2) begin
                  state_d = S_OWN2;
                  cnt_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (HOLD_EN) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_OWN2: begin
            if (!A2 || hold_hit) begin
               pri2_d = 1'b0;
               if (A2) begin
                  to_d   = 1'b1;
                  blk2_d = 1'b1;
               end
               if (e1) begin
                  state_d = S_OWN1;
                  cnt_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (HOLD_EN) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      g1_d = (state_d == S_OWN1);
      g2_d = (state_d == S_OWN2);
      z_d  = g1_d | g2_d;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         pri2_q  <= 1'b0;
         cnt_q   <= '0;
         blk1_q  <= 1'b0;
         blk2_q  <= 1'b0;
         g1_q    <= 1'b0;
         g2_q    <= 1'b0;
         z_q     <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pri2_q  <= pri2_d;
         cnt_q   <= cnt_d;
         blk1_q  <= blk1_d;
         blk2_q  <= blk2_d;
         g1_q    <= g1_d;
         g2_q    <= g2_d;
         z_q     <= z_d;
         to_q    <= to_d;
      end
   end

   assign G1 = g1_q;
   assign G2 = g2_q;
   assign Z  = z_q;
   assign TO = to_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_rr_arb2.sv
// Bench for the two-requester round-robin arbiter: three instances (hold limit
// 16, 4 and disabled) share stimulus and are compared against an ownership model.
module tb_gf180mcu_fd_sc_mcu9t5v0_rr_arb2;

   logic       CLK;
   logic       RST;
   logic       A1;
   logic       A2;
   logic [2:0] g1_w, g2_w, z_w, to_w;

   int checks = 0;
   int errors = 0;

   // reference model: who owns, how long, who is favoured, who is blocked
   int       mh      [3] = '{16, 4, 0};
   int       m_owner [3];
   int       m_held  [3];
   int       m_fav   [3];
   bit [2:1] m_blk   [3];
   bit       m_to    [3];

   gf180mcu_fd_sc_mcu9t5v0_rr_arb2 #(.HCW(8), .MAX_HOLD(16)) u_h16 (
      .CLK(CLK), .RST(RST), .A1(A1), .A2(A2),
      .G1(g1_w[0]), .G2(g2_w[0]), .Z(z_w[0]), .TO(to_w[0]));

   gf180mcu_fd_sc_mcu9t5v0_rr_arb2 #(.HCW(8), .MAX_HOLD(4)) u_h4 (
      .CLK(CLK), .RST(RST), .A1(A1), .A2(A2),
      .G1(g1_w[1]), .G2(g2_w[1]), .Z(z_w[1]), .TO(to_w[1]));

   gf180mcu_fd_sc_mcu9t5v0_rr_arb2 #(.HCW(4), .MAX_HOLD(0)) u_h0 (
      .CLK(CLK), .RST(RST), .A1(A1), .A2(A2),
      .G1(g1_w[2]), .G2(g2_w[2]), .Z(z_w[2]), .TO(to_w[2]));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_owner[k] = 0;
         m_held[k]  = 0;
         m_fav[k]   = 1;
         m_blk[k]   = 2'b00;
         m_to[k]    = 1'b0;
      end
   endtask

   task automatic model_edge(input bit a1, input bit a2);
      bit [2:1] req;
      bit [2:1] el;
      bit [2:1] nb;
      int       o;
      int       oth;
      req = {a2, a1};
      for (int k = 0; k < 3; k++) begin
         el       = req & ~m_blk[k];
         nb       = m_blk[k] & req;
         m_to[k]  = 1'b0;
         o        = m_owner[k];
         if (o == 0) begin
            if (el[1] && el[2]) o = m_fav[k];
            else if (el[1])     o = 1;
            else if (el[2])     o = 2;
            if (o != 0) m_held[k] = 1;
         end else if (!req[o] || (mh[k] > 0 && m_held[k] == mh[k])) begin
            oth      = 3 - o;
            m_fav[k] = oth;
            if (req[o]) begin
               m_to[k] = 1'b1;
               nb[o]   = 1'b1;
            end
            if (el[oth]) begin
               o         = oth;
               m_held[k] = 1;
            end else begin
               o = 0;
            end
         end else begin
            m_held[k]++;
         end
         m_owner[k] = o;
         m_blk[k]   = nb;
      end
   endtask

   task automatic check_all();
      logic e1, e2;
      for (int k = 0; k < 3; k++) begin
         e1 = (m_owner[k] == 1);
         e2 = (m_owner[k] == 2);
         checks++;
         assert (g1_w[k] === e1) else begin
            errors++;
            $error("FAIL g1 inst%0d t=%0t observed=%b expected=%b", k, $time, g1_w[k], e1);
         end
         checks++;
         assert (g2_w[k] === e2) else begin
            errors++;
            $error("FAIL g2 inst%0d t=%0t observed=%b expected=%b", k, $time, g2_w[k], e2);
         end
         checks++;
         assert (z_w[k] === (e1 | e2)) else begin
            errors++;
            $error("FAIL z inst%0d t=%0t observed=%b expected=%b", k, $time, z_w[k], e1 | e2);
         end
         checks++;
         assert (to_w[k] === m_to[k]) else begin
            errors++;
            $error("FAIL to inst%0d t=%0t observed=%b expected=%b", k, $time, to_w[k], m_to[k]);
         end
         checks++;
         assert (!(g1_w[k] && g2_w[k])) else begin
            errors++;
            $error("FAIL overlap inst%0d t=%0t observed=%b%b expected=not 11", k, $time, g1_w[k], g2_w[k]);
         end
      end
   endtask

   task automatic step(input bit a1, input bit a2);
      A1 = a1;
      A2 = a2;
      @(posedge CLK);
      if (RST) model_reset();
      else     model_edge(a1, a2);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      A1  = 1'b0;
      A2  = 1'b0;
      RST = 1'b1;
      #2;
      model_reset();
      check_all();
      @(posedge CLK);
      #1;
      check_all();
      RST = 1'b0;
   endtask

   task automatic expect_count(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   initial begin
      int n_g1, n_g2, n_to, n_z0;
      bit ra1, ra2;
      RST = 1'b1;
      A1  = 1'b0;
      A2  = 1'b0;
      model_reset();
      #1;
      check_all();
      do_reset();

      // single requester: A1 high 5 sampled cycles then low
      n_g1 = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0);
         if (g1_w[0]) n_g1++;
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0);
         if (g1_w[0]) n_g1++;
      end
      expect_count("single_g1_cycles", n_g1, 5);

      // contention from reset, A1 drops after 3 grant cycles, Z must stay high
      do_reset();
      n_z0 = 0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1);
         if (!z_w[0]) n_z0++;
      end
      expect_count("handover_z_low", n_z0, 0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      expect_count("regrant_g1", int'(g1_w[0]), 1);
      step(1'b0, 1'b0);

      // hold limit with A1 alone held for 20 cycles
      do_reset();
      n_g1 = 0;
      n_to = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0);
         if (g1_w[1])  n_g1++;
         if (to_w[1])  n_to++;
      end
      expect_count("limit_g1_cycles", n_g1, 4);
      expect_count("limit_to_pulses", n_to, 1);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      expect_count("limit_regrant", int'(g1_w[1]), 1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // hold limit with a waiting peer: 4 + 4, then both blocked
      do_reset();
      n_g1 = 0;
      n_g2 = 0;
      n_to = 0;
      for (int i = 0; i < 14; i++) begin
         step(1'b1, 1'b1);
         if (g1_w[1]) n_g1++;
         if (g2_w[1]) n_g2++;
         if (to_w[1]) n_to++;
      end
      expect_count("peer_g1_cycles", n_g1, 4);
      expect_count("peer_g2_cycles", n_g2, 4);
      expect_count("peer_to_pulses", n_to, 2);
      expect_count("peer_blocked_z", int'(z_w[1]), 0);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // A1 falls on the sample where the limit is reached: plain release
      do_reset();
      n_to = 0;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      if (to_w[1]) n_to++;
      step(1'b1, 1'b0);
      if (to_w[1]) n_to++;
      expect_count("boundary_to", n_to, 0);
      expect_count("boundary_regrant", int'(g1_w[1]), 1);
      step(1'b0, 1'b0);

      // one-cycle request glitch on each side
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // asynchronous reset while G2 is held
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      #3;
      RST = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge CLK);
      #1;
      check_all();
      #2;
      RST = 1'b0;
      step(1'b1, 1'b1);
      expect_count("post_reset_g1", int'(g1_w[0]), 1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // randomized level requests with occasional resets
      ra1 = 1'b0;
      ra2 = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(3) == 0) ra1 = ~ra1;
         if ($urandom_range(3) == 0) ra2 = ~ra2;
         if ($urandom_range(299) == 0) do_reset();
         step(ra1, ra2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
